// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: ping-pong line-buffer fetch from a framebuffer RAM with round-robin CPU write arbitration.
module vga_fb_arbiter #(
  parameter int FB_W  = 160,
  parameter int FB_H  = 120,
  parameter int SCALE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        cpu_req,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel,
  output logic        fetch_busy,
  output logic        underrun
);
  localparam int CW = $clog2(FB_W);
  localparam int RW = $clog2(FB_H);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d, trig_row;
  logic [CW-1:0] col_q, col_d, cap_col_q, sx;
  logic [9:0] sy;
  logic cap_vld_q, cap_buf_q, rr_q, rr_d, underrun_q, underrun_d;
  logic [7:0] pixel_q, pixel_d;
  logic [7:0] lb_q [2][FB_W];
  logic trig, busy, fetch_want, fetch_gnt, cpu_gnt;
  assign sx = CW'(x / 10'(SCALE));
  assign sy = y / 10'(SCALE);
  assign busy = state_q != IDLE;
  // Row 0 is fetched during the last blanking line; row r+1 on the first line of row r.
  assign trig = x == '0 && (y == 10'd524 || (y % 10'(SCALE) == '0 && y < 10'(SCALE * (FB_H - 1))));
  assign trig_row = y == 10'd524 ? '0 : RW'(sy + 10'd1);
  // rr_q set means the CPU owns the next contended slot.
  assign fetch_want = state_q == FETCH && !trig;
  assign fetch_gnt = fetch_want && !(cpu_req && rr_q);
  assign cpu_gnt = reset_n && cpu_req && !fetch_gnt;
  assign cpu_ack = cpu_gnt;
  assign mem_en = fetch_gnt || cpu_gnt;
  assign mem_we = cpu_gnt;
  assign mem_addr = cpu_gnt ? cpu_addr : 15'(row_q) * 15'(FB_W) + 15'(col_q);
  assign mem_wdata = cpu_wdata;
  assign pixel = pixel_q;
  assign fetch_busy = busy;
  assign underrun = underrun_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    rr_d = cpu_gnt ? 1'b0 : (fetch_gnt && cpu_req) ? 1'b1 : rr_q;
    underrun_d = underrun_q || (trig && busy);
    pixel_d = (video_on && x < 10'(FB_W * SCALE) && y < 10'(FB_H * SCALE)) ? lb_q[sy[0]][sx] : '0;
    if (trig) begin
      state_d = FETCH;
      row_d = trig_row;
      col_d = '0;
    end else if (fetch_gnt) begin
      col_d = col_q + 1'b1;
      state_d = col_q == CW'(FB_W - 1) ? DRAIN : FETCH;
    end else if (state_q == DRAIN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      cap_vld_q <= 1'b0;
      cap_buf_q <= 1'b0;
      cap_col_q <= '0;
      rr_q <= 1'b0;
      underrun_q <= 1'b0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      cap_vld_q <= fetch_gnt;
      cap_buf_q <= row_q[0];
      cap_col_q <= col_q;
      rr_q <= rr_d;
      underrun_q <= underrun_d;
      pixel_q <= pixel_d;
    end
  end
  always_ff @(posedge clk) begin
    if (cap_vld_q) lb_q[cap_buf_q][cap_col_q] <= mem_rdata;
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of line fetch, pixel output, CPU arbitration, underrun and reset.
module tb_vga_fb_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic [9:0] x, y;
  logic video_on, cpu_req, cpu_ack, mem_en, mem_we, fetch_busy, underrun;
  logic [14:0] cpu_addr, mem_addr;
  logic [7:0] cpu_wdata, mem_wdata, mem_rdata, pixel;
  logic [7:0] ram [32768];
  int errors = 0, checks = 0;
  int b, r, bad, acks, w, maxw, k;
  logic got;

  vga_fb_arbiter dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel(pixel), .fetch_busy(fetch_busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32768; i++) ram[i] = 8'(i);

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input int base, output int busy_n, output int reads, output int bad_n);
    busy_n = 0;
    reads = 0;
    bad_n = 0;
    while (fetch_busy && busy_n < 400) begin
      if (mem_en && !mem_we) begin
        if (mem_addr != 15'(base + reads)) bad_n++;
        reads++;
      end
      busy_n++;
      cyc();
    end
  endtask

  task automatic pix(input string tag, input int xv, input int yv, input logic [7:0] exp_v);
    x = 10'(xv);
    y = 10'(yv);
    cyc();
    check(tag, pixel, exp_v);
  endtask

  initial begin
    reset_n = 1'b0;
    x = 10'd1; y = 10'd1; video_on = 1'b0;
    cpu_req = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) cyc();
    check("rst_ack", cpu_ack, 0);
    check("rst_en", mem_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_pixel", pixel, 0);
    cpu_req = 1'b0;
    reset_n = 1'b1;
    cyc();

    x = 10'd0; y = 10'd524;
    cyc();
    x = 10'd1; y = 10'd1;
    #1;
    run_fetch(0, b, r, bad);
    check("row0_done", b > 0 && b <= 162, 1);
    check("row0_reads", r, 160);
    check("row0_addr", bad, 0);
    video_on = 1'b1;
    for (int i = 0; i < 8; i++) pix("pix_row0", i, 1, 8'(i / 4));
    pix("pix_row0_trig", 0, 0, 8'h00);
    x = 10'd1;
    #1;
    run_fetch(160, b, r, bad);
    check("row1_reads", r, 160);
    check("row1_addr", bad, 0);
    pix("pix_row1_c0", 0, 5, 8'hA0);
    pix("pix_row1_c159", 639, 5, 8'h3F);

    video_on = 1'b0;
    cpu_req = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hA5;
    #1;
    check("idle_ack", cpu_ack, 1);
    check("idle_en", mem_en, 1);
    check("idle_we", mem_we, 1);
    check("idle_addr", mem_addr, 15'h1234);
    check("idle_wdata", mem_wdata, 8'hA5);
    cyc();
    cpu_addr = 15'h7FFF; cpu_wdata = 8'h5A;
    #1;
    check("oob_ack", cpu_ack, 1);
    check("oob_addr", mem_addr, 15'h7FFF);
    cyc();
    cpu_req = 1'b0;
    #1;
    check("idle_no_en", mem_en, 0);
    check("ram_1234", ram[15'h1234], 8'hA5);
    check("ram_7fff", ram[15'h7FFF], 8'h5A);

    x = 10'd0; y = 10'd4;
    cyc();
    x = 10'd1; y = 10'd5;
    k = 0; cpu_req = 1'b1; cpu_addr = 15'h5000; cpu_wdata = 8'h00;
    #1;
    b = 0; r = 0; bad = 0; acks = 0; w = 0; maxw = 0;
    while (fetch_busy && b < 700) begin
      if (mem_en && !mem_we) begin
        if (mem_addr != 15'(320 + r)) bad++;
        r++;
      end
      got = cpu_ack;
      if (got) begin
        acks++;
        w = 0;
      end else begin
        w++;
        if (w > maxw) maxw = w;
      end
      b++;
      cyc();
      if (got) begin
        k++;
        cpu_addr = 15'(15'h5000 + k);
        cpu_wdata = 8'(k);
      end
      #1;
    end
    cpu_req = 1'b0;
    cyc();
    check("rr_busy_cycles", b, 320);
    check("rr_reads", r, 160);
    check("rr_addr", bad, 0);
    check("rr_max_wait", maxw <= 1, 1);
    check("rr_acks", acks, 160);
    check("rr_ram_5", ram[15'h5005], 8'h05);
    check("rr_ram_159", ram[15'h5000 + 159], 8'h9F);
    video_on = 1'b1;
    pix("pix_row2_c0", 0, 9, 8'h40);
    pix("pix_row2_c159", 639, 9, 8'hDF);

    video_on = 1'b0;
    x = 10'd0; y = 10'd472;
    cyc();
    x = 10'd1;
    #1;
    check("row119_busy", fetch_busy, 1);
    run_fetch(119 * 160, b, r, bad);
    check("row119_reads", r, 160);
    check("row119_addr", bad, 0);
    x = 10'd0; y = 10'd476;
    cyc();
    check("no_fetch_120", fetch_busy, 0);
    check("no_fetch_en", mem_en, 0);
    video_on = 1'b1;
    pix("pix_last", 639, 479, 8'hFF);
    pix("pix_y480", 0, 480, 8'h00);
    pix("pix_x640", 640, 10, 8'h00);
    video_on = 1'b0;
    pix("pix_blank", 4, 1, 8'h00);

    cpu_req = 1'b1; cpu_addr = 15'h6000; cpu_wdata = 8'h3C;
    x = 10'd0; y = 10'd8;
    cyc();
    x = 10'd1;
    #1;
    repeat (10) cyc();
    check("ur_before", underrun, 0);
    check("ur_busy_before", fetch_busy, 1);
    x = 10'd0; y = 10'd12;
    cyc();
    x = 10'd1;
    #1;
    check("ur_set", underrun, 1);
    check("ur_busy_after", fetch_busy, 1);
    run_fetch(640, b, r, bad);
    check("ur_new_reads", r, 160);
    check("ur_new_addr", bad, 0);
    cpu_req = 1'b0;
    repeat (5) cyc();
    check("ur_sticky", underrun, 1);

    x = 10'd0; y = 10'd16;
    cyc();
    x = 10'd1;
    #1;
    repeat (5) cyc();
    check("abort_busy_pre", fetch_busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_en", mem_en, 0);
    check("abort_busy", fetch_busy, 0);
    check("abort_underrun", underrun, 0);
    cyc();
    reset_n = 1'b1;
    repeat (5) cyc();
    check("post_rst_idle", fetch_busy, 0);
    check("post_rst_en", mem_en, 0);
    x = 10'd0; y = 10'd524;
    cyc();
    x = 10'd1; y = 10'd1;
    #1;
    run_fetch(0, b, r, bad);
    check("post_rst_done", b > 0 && b <= 162, 1);
    check("post_rst_reads", r, 160);
    check("post_rst_addr", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
